// File: rtl/synth_voice_engine.sv
// synth_voice_engine
//   Time-multiplexed N-voice oscillator and mixer. One shared phase / wave /
//   multiply datapath serves NUM_UNITS voices, one voice per ctl_clk cycle, and
//   produces one saturated signed sample per audio frame.
//
//   Optional feature macro: SYNTH_NOISE_EN
//     defined   -> wave_type 3 selects a shared 16-bit Galois LFSR noise source
//     undefined -> no LFSR logic; wave_type 3 yields a zero sample (phase still advances)
//
// Ports
//   ctl_clk    in   system clock
//   ctl_rst    in   asynchronous reset, active-high
//   aud_freq   in   sample-rate tick; a rising edge starts a frame
//   freq_in    in   per-voice frequency words (voice i at [FREQ_WIDTH*i +: FREQ_WIDTH])
//   amp_in     in   per-voice unsigned amplitudes, same packing
//   wave_type  in   per-voice 2-bit wave select (0 square, 1 saw, 2 triangle, 3 noise)
//   wave_out   out  registered signed mixed sample
//   wave_valid out  one-cycle pulse when wave_out updates
//   busy       out  high while a frame is in progress
//   overrun    out  sticky flag: an aud_freq edge arrived while busy
//   state_dbg  out  current FSM state (0 idle, 1 run, 2 done)
//
// Handshake: wave_valid is a single-cycle strobe with no ready; the consumer must
// capture wave_out in the cycle wave_valid is high. aud_freq edges that arrive while
// busy are dropped and recorded in overrun.
module synth_voice_engine #(
    parameter int BITWIDTH    = 24,
    parameter int FIXED_POINT = 8,
    parameter int NUM_UNITS   = 4,
    parameter int FREQ_WIDTH  = 16,
    parameter int AMP_WIDTH   = 16,
    parameter int PHASE_WIDTH = 24,
    parameter int PHASE_STEP  = 350
) (
    input  logic                            ctl_clk,
    input  logic                            ctl_rst,
    input  logic                            aud_freq,
    input  logic [FREQ_WIDTH*NUM_UNITS-1:0] freq_in,
    input  logic [AMP_WIDTH*NUM_UNITS-1:0]  amp_in,
    input  logic [2*NUM_UNITS-1:0]          wave_type,
    output logic signed [BITWIDTH-1:0]      wave_out,
    output logic                            wave_valid,
    output logic                            busy,
    output logic                            overrun,
    output logic [1:0]                      state_dbg
);

    localparam int CH_W   = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int ACC_W  = 16 + AMP_WIDTH + 1 - FIXED_POINT + $clog2(NUM_UNITS) + 1;
    localparam int PROD_W = 16 + AMP_WIDTH + 1;
    localparam int CMP_W  = (ACC_W > BITWIDTH) ? ACC_W : BITWIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_n;

    logic                    aud_q;
    logic                    rise;
    logic                    start;
    logic                    done;
    logic                    last_ch;
    logic [CH_W-1:0]         ch;
    logic signed [ACC_W-1:0] acc;
    logic [PHASE_WIDTH-1:0]  phase [NUM_UNITS];

    // Frame snapshot of the voice controls, taken when a frame starts.
    logic [FREQ_WIDTH-1:0]   snap_freq [NUM_UNITS];
    logic [AMP_WIDTH-1:0]    snap_amp  [NUM_UNITS];
    logic [1:0]              snap_wave [NUM_UNITS];

    logic [PHASE_WIDTH-1:0]  p;
    logic [PHASE_WIDTH-1:0]  inc;
    logic [15:0]             tri_t;
    logic signed [15:0]      raw;
    logic signed [AMP_WIDTH:0] amp_s;
    logic signed [PROD_W-1:0]  prod;
    logic signed [PROD_W-1:0]  scaled;
    logic signed [CMP_W-1:0]   acc_ext;
    logic signed [CMP_W-1:0]   sat_max;
    logic signed [CMP_W-1:0]   sat_min;
    logic signed [BITWIDTH-1:0] sat_val;

    assign rise    = aud_freq & ~aud_q;
    assign last_ch = (ch == CH_W'(NUM_UNITS - 1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge ctl_clk or posedge ctl_rst) begin
        if (ctl_rst) state <= S_IDLE;
        else         state <= state_n;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (rise) state_n = S_RUN;
            S_RUN:   if (last_ch) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy      = (state != S_IDLE);
        start     = (state == S_IDLE) && rise;
        done      = (state == S_DONE);
        state_dbg = state;
    end

    // ---------------- Snapshot ----------------
    always_ff @(posedge ctl_clk) begin
        if (start) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                snap_freq[i] <= freq_in[FREQ_WIDTH*i +: FREQ_WIDTH];
                snap_amp[i]  <= amp_in[AMP_WIDTH*i +: AMP_WIDTH];
                snap_wave[i] <= wave_type[2*i +: 2];
            end
        end
    end

`ifdef SYNTH_NOISE_EN
    logic [15:0] lfsr;

    // Galois LFSR, x^16+x^14+x^13+x^11; advances once per completed frame so
    // every noise voice in one frame sees the same value.
    always_ff @(posedge ctl_clk or posedge ctl_rst) begin
        if (ctl_rst)   lfsr <= 16'hACE1;
        else if (done) lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
`endif

    // ---------------- Shared voice datapath ----------------
    always_comb begin
        p     = phase[ch];
        inc   = PHASE_WIDTH'(snap_freq[ch]) * PHASE_WIDTH'(PHASE_STEP);
        tri_t = p[PHASE_WIDTH-2 -: 16];
        if (p[PHASE_WIDTH-1]) tri_t = ~tri_t;
        raw = '0;
        case (snap_wave[ch])
            2'd0:    raw = p[PHASE_WIDTH-1] ? 16'sh8000 : 16'sh7FFF;
            2'd1:    raw = $signed(p[PHASE_WIDTH-1 -: 16] ^ 16'h8000);
            2'd2:    raw = $signed(tri_t ^ 16'h8000);
`ifdef SYNTH_NOISE_EN
            default: raw = $signed(lfsr);
`else
            default: raw = '0;
`endif
        endcase
        amp_s  = $signed({1'b0, snap_amp[ch]});
        prod   = raw * amp_s;
        scaled = prod >>> FIXED_POINT;
    end

    // ---------------- Output saturation ----------------
    always_comb begin
        acc_ext = CMP_W'(acc);
        sat_max = CMP_W'($signed({1'b0, {(BITWIDTH-1){1'b1}}}));
        sat_min = CMP_W'($signed({1'b1, {(BITWIDTH-1){1'b0}}}));
        if (acc_ext > sat_max)      sat_val = {1'b0, {(BITWIDTH-1){1'b1}}};
        else if (acc_ext < sat_min) sat_val = {1'b1, {(BITWIDTH-1){1'b0}}};
        else                        sat_val = acc_ext[BITWIDTH-1:0];
    end

    // ---------------- Sequential datapath ----------------
    always_ff @(posedge ctl_clk or posedge ctl_rst) begin
        if (ctl_rst) begin
            aud_q      <= 1'b0;
            acc        <= '0;
            ch         <= '0;
            wave_out   <= '0;
            wave_valid <= 1'b0;
            overrun    <= 1'b0;
            for (int i = 0; i < NUM_UNITS; i++) phase[i] <= '0;
        end else begin
            aud_q      <= aud_freq;
            wave_valid <= done;
            if (rise && busy) overrun <= 1'b1;
            if (start) begin
                acc <= '0;
                ch  <= '0;
            end
            if (state == S_RUN) begin
                acc       <= acc + ACC_W'(scaled);
                phase[ch] <= p + inc;
                ch        <= ch + 1'b1;
            end
            if (done) wave_out <= sat_val;
        end
    end

endmodule

// File: tb/tb_synth_voice_engine.sv
// Testbench for synth_voice_engine: directed and random frames checked against a
// frame-level arithmetic model (per-voice waveform value from phase, scaled sum,
// clamp), plus reset, latency, busy, snapshot and overrun behaviour.
module tb_synth_voice_engine;

    localparam int N = 4;

    logic          ctl_clk;
    logic          ctl_rst;
    logic          aud_freq;
    logic [63:0]   freq_in;
    logic [63:0]   amp_in;
    logic [7:0]    wave_type;
    logic [23:0]   wave_out;
    logic          wave_valid;
    logic          busy;
    logic          overrun;
    logic [1:0]    state_dbg;

    int n_pass  = 0;
    int n_total = 0;

    // Stimulus configuration and reference-model state
    int          cf [N];
    int          ca [N];
    int          cw [N];
    int unsigned mphase [N];
    int unsigned mlfsr;
    logic        exp_ovr;

    synth_voice_engine dut (
        .ctl_clk   (ctl_clk),
        .ctl_rst   (ctl_rst),
        .aud_freq  (aud_freq),
        .freq_in   (freq_in),
        .amp_in    (amp_in),
        .wave_type (wave_type),
        .wave_out  (wave_out),
        .wave_valid(wave_valid),
        .busy      (busy),
        .overrun   (overrun),
        .state_dbg (state_dbg)
    );

    // ---------------- Clock ----------------
    initial ctl_clk = 1'b0;
    always #5 ctl_clk = ~ctl_clk;

    // ---------------- Checker ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // ---------------- Reference model ----------------
    function automatic int raw_of(int w, int unsigned ph, int unsigned lf);
        int t;
        case (w)
            0: return (ph < 32'h0080_0000) ? 32767 : -32768;
            1: return int'(ph >> 8) - 32768;
            2: begin
                t = int'((ph >> 7) & 32'hFFFF);
                if (ph >= 32'h0080_0000) t = 65535 - t;
                return t - 32768;
            end
            default: begin
`ifdef SYNTH_NOISE_EN
                return (lf >= 32768) ? int'(lf) - 65536 : int'(lf);
`else
                return 0;
`endif
            end
        endcase
    endfunction

    function automatic logic [23:0] model_frame();
        longint sum = 0;
        longint prod;
        for (int i = 0; i < N; i++) begin
            prod = longint'(raw_of(cw[i], mphase[i], mlfsr)) * longint'(ca[i]);
            sum += prod >>> 8;
        end
        if (sum > 64'sd8388607)   sum = 64'sd8388607;
        if (sum < -64'sd8388608)  sum = -64'sd8388608;
        return sum[23:0];
    endfunction

    task automatic model_advance();
        for (int i = 0; i < N; i++)
            mphase[i] = (mphase[i] + cf[i] * 350) & 32'h00FF_FFFF;
        mlfsr = (mlfsr >> 1) ^ (((mlfsr & 1) != 0) ? 32'hB400 : 32'h0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) mphase[i] = 0;
        mlfsr   = 32'hACE1;
        exp_ovr = 1'b0;
    endtask

    // ---------------- Drivers ----------------
    task automatic drive_cfg();
        for (int i = 0; i < N; i++) begin
            freq_in[16*i +: 16] = cf[i][15:0];
            amp_in[16*i +: 16]  = ca[i][15:0];
            wave_type[2*i +: 2] = cw[i][1:0];
        end
    endtask

    task automatic set_all(input int f, input int a, input int w);
        for (int i = 0; i < N; i++) begin
            cf[i] = f; ca[i] = a; cw[i] = w;
        end
    endtask

    // Runs one frame. second_off > 0 raises a second aud_freq edge that is
    // sampled second_off clock edges after the frame-starting edge.
    task automatic run_frame(input int second_off, input string tag);
        logic [23:0] exp_w;
        logic [23:0] got;
        int valid_cnt;
        int first_k;
        exp_w     = model_frame();
        valid_cnt = 0;
        first_k   = -1;
        got       = '0;
        drive_cfg();
        @(posedge ctl_clk); #1 aud_freq = 1'b1;
        @(posedge ctl_clk); #1 aud_freq = 1'b0;
        // Inputs changing mid-frame must not affect this frame.
        freq_in   = {$urandom, $urandom};
        amp_in    = {$urandom, $urandom};
        wave_type = 8'($urandom);
        if (second_off > 0) exp_ovr = 1'b1;
        for (int k = 1; k <= N + 8; k++) begin
            @(negedge ctl_clk);
            if (k == second_off)     aud_freq = 1'b1;
            if (k == second_off + 1) aud_freq = 1'b0;
            chk({tag, "_busy"}, 32'(busy), 32'(k <= N + 1));
            if (wave_valid) begin
                valid_cnt++;
                if (first_k < 0) begin
                    first_k = k;
                    got     = wave_out;
                end
            end
        end
        chk({tag, "_valid_cnt"}, 32'(valid_cnt), 32'd1);
        chk({tag, "_latency"},   32'(first_k),   32'(N + 2));
        chk({tag, "_wave"},      32'(got),       32'(exp_w));
        chk({tag, "_overrun"},   32'(overrun),   32'(exp_ovr));
        model_advance();
    endtask

    task automatic apply_reset();
        @(negedge ctl_clk);
        ctl_rst = 1'b1;
        repeat (3) @(negedge ctl_clk);
        ctl_rst = 1'b0;
        model_reset();
    endtask

    // ---------------- Stimulus ----------------
    initial begin
        ctl_rst   = 1'b1;
        aud_freq  = 1'b0;
        freq_in   = '0;
        amp_in    = '0;
        wave_type = '0;
        model_reset();
        repeat (3) @(negedge ctl_clk);
        chk("rst_wave_out", 32'(wave_out),   32'd0);
        chk("rst_valid",    32'(wave_valid), 32'd0);
        chk("rst_busy",     32'(busy),       32'd0);
        chk("rst_overrun",  32'(overrun),    32'd0);
        ctl_rst = 1'b0;

        // Saw at frozen phase 0
        set_all(0, 0, 0);
        cw[0] = 1; ca[0] = 16'h100;
        run_frame(0, "saw0");
        run_frame(0, "saw1");

        // Positive saturation: four full-scale squares at phase 0
        set_all(0, 16'hFFFF, 0);
        run_frame(0, "sat_pos");

        // Reset during RUN aborts the frame
        set_all(12000, 16'h100, 0);
        drive_cfg();
        @(posedge ctl_clk); #1 aud_freq = 1'b1;
        @(posedge ctl_clk); #1 aud_freq = 1'b0;
        repeat (2) @(negedge ctl_clk);
        ctl_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge ctl_clk);
            chk("midrst_wave_out", 32'(wave_out),   32'd0);
            chk("midrst_busy",     32'(busy),       32'd0);
            chk("midrst_valid",    32'(wave_valid), 32'd0);
        end
        ctl_rst = 1'b0;
        model_reset();
        begin
            int seen = 0;
            repeat (8) begin
                @(negedge ctl_clk);
                if (wave_valid) seen++;
            end
            chk("midrst_no_valid", 32'(seen), 32'd0);
        end

        // Square on voice 0 from phase 0, four frames
        set_all(0, 0, 0);
        cf[0] = 12000; ca[0] = 16'h100;
        for (int f = 0; f < 4; f++) run_frame(0, "square");

        // Random frames
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < N; i++) begin
                cf[i] = int'($urandom_range(0, 65535));
                ca[i] = int'($urandom_range(0, 65535));
                cw[i] = int'($urandom_range(0, 3));
            end
            run_frame(0, "rand");
        end

        // Noise on voice 0
        set_all(0, 0, 0);
        cw[0] = 3; ca[0] = 16'h100; cf[0] = 500;
        for (int f = 0; f < 3; f++) run_frame(0, "noise");

        // Edge during RUN is dropped and sets overrun
        apply_reset();
        chk("ovr_clear0", 32'(overrun), 32'd0);
        set_all(1000, 16'h4000, 2);
        run_frame(2, "ovr_run");

        // Edge landing in the DONE cycle also counts as busy
        apply_reset();
        chk("ovr_clear1", 32'(overrun), 32'd0);
        set_all(3000, 16'h2000, 1);
        run_frame(N + 1, "ovr_done");

        apply_reset();
        @(negedge ctl_clk);
        chk("ovr_clear2", 32'(overrun), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
